// File: rtl/axi_rd_arbiter.sv
// Purpose : two-requester AXI4 read arbiter; round-robin AR grant with the
//           requester index prepended to ARID, R beats routed back on the ID MSB,
//           and a per-requester cap on in-flight bursts.
// Latency : AR 1 cycle (s_arvalid -> m_arvalid); R path combinational, zero latency.
// Backpr. : m_arready stalls the held AR in ISSUE (no new grants meanwhile);
//           s_rready of the addressed requester drives m_rready directly.
// Ports   : clk/rst_n; s_ar* (2 requesters, requester 0 in low slices), s_r* (broadcast
//           payload, routed valid); m_ar* (registered request), m_r* (shared return).
module axi_rd_arbiter #(
  parameter int ID_WIDTH        = 7,
  parameter int ADDR_WIDTH      = 64,
  parameter int DATA_WIDTH      = 512,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  // requester-side AR
  input  logic [2*ID_WIDTH-1:0]   s_arid,
  input  logic [2*ADDR_WIDTH-1:0] s_araddr,
  input  logic [15:0]             s_arlen,
  input  logic [5:0]              s_arsize,
  input  logic [3:0]              s_arburst,
  input  logic [1:0]              s_arvalid,
  output logic [1:0]              s_arready,
  // requester-side R
  output logic [2*ID_WIDTH-1:0]   s_rid,
  output logic [2*DATA_WIDTH-1:0] s_rdata,
  output logic [3:0]              s_rresp,
  output logic [1:0]              s_rlast,
  output logic [1:0]              s_rvalid,
  input  logic [1:0]              s_rready,
  // master-side AR
  output logic [ID_WIDTH:0]       m_arid,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic [7:0]              m_arlen,
  output logic [2:0]              m_arsize,
  output logic [1:0]              m_arburst,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  // master-side R
  input  logic [ID_WIDTH:0]       m_rid,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rlast,
  input  logic                    m_rvalid,
  output logic                    m_rready
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_t;

  localparam logic [3:0] CNT_MAX = 4'(MAX_OUTSTANDING);

  state_t                r_state;
  logic                  r_ptr;      // requester holding priority next grant
  logic [3:0]            r_cnt0;
  logic [3:0]            r_cnt1;
  logic [ID_WIDTH:0]     r_arid;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [7:0]            r_arlen;
  logic [2:0]            r_arsize;
  logic [1:0]            r_arburst;
  logic                  r_arvalid;

  logic [1:0]            w_elig;
  logic                  w_grant_vld;
  logic                  w_grant_idx;
  logic [ID_WIDTH-1:0]   w_arid;
  logic [ADDR_WIDTH-1:0] w_araddr;
  logic [7:0]            w_arlen;
  logic [2:0]            w_arsize;
  logic [1:0]            w_arburst;
  logic                  w_sel;
  logic                  w_rdone;
  logic [1:0]            w_inc;
  logic [1:0]            w_dec;

  // Grants only happen from IDLE, which caps AR issue at one per two cycles.
  assign w_elig[0]   = s_arvalid[0] && (r_cnt0 < CNT_MAX);
  assign w_elig[1]   = s_arvalid[1] && (r_cnt1 < CNT_MAX);
  assign w_grant_vld = (r_state == ST_IDLE) && (|w_elig);
  assign w_grant_idx = w_elig[r_ptr] ? r_ptr : ~r_ptr;

  assign s_arready = w_grant_vld ? (w_grant_idx ? 2'b10 : 2'b01) : 2'b00;

  assign w_arid    = w_grant_idx ? s_arid[2*ID_WIDTH-1:ID_WIDTH]       : s_arid[ID_WIDTH-1:0];
  assign w_araddr  = w_grant_idx ? s_araddr[2*ADDR_WIDTH-1:ADDR_WIDTH] : s_araddr[ADDR_WIDTH-1:0];
  assign w_arlen   = w_grant_idx ? s_arlen[15:8]   : s_arlen[7:0];
  assign w_arsize  = w_grant_idx ? s_arsize[5:3]   : s_arsize[2:0];
  assign w_arburst = w_grant_idx ? s_arburst[3:2]  : s_arburst[1:0];

  // R routing: the prefix bit picks the requester; payload is broadcast.
  assign w_sel    = m_rid[ID_WIDTH];
  assign s_rvalid = w_sel ? {m_rvalid, 1'b0} : {1'b0, m_rvalid};
  assign m_rready = s_rready[w_sel];
  assign s_rid    = {2{m_rid[ID_WIDTH-1:0]}};
  assign s_rdata  = {2{m_rdata}};
  assign s_rresp  = {2{m_rresp}};
  assign s_rlast  = {2{m_rlast}};

  // A burst retires on its last accepted beat.
  assign w_rdone  = m_rvalid & m_rready & m_rlast;
  assign w_inc[0] = w_grant_vld & ~w_grant_idx;
  assign w_inc[1] = w_grant_vld &  w_grant_idx;
  assign w_dec[0] = w_rdone & ~w_sel;
  assign w_dec[1] = w_rdone &  w_sel;

  // Simultaneous inc/dec cancel; a stray decrement at zero saturates.
  function automatic logic [3:0] cnt_next(input logic [3:0] c, input logic inc, input logic dec);
    logic [3:0] n;
    n = c;
    if (inc && !dec)      n = c + 4'd1;
    else if (dec && !inc) n = (c == 4'd0) ? 4'd0 : c - 4'd1;
    return n;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_ptr     <= 1'b0;
      r_cnt0    <= 4'd0;
      r_cnt1    <= 4'd0;
      r_arid    <= '0;
      r_araddr  <= '0;
      r_arlen   <= '0;
      r_arsize  <= '0;
      r_arburst <= '0;
      r_arvalid <= 1'b0;
    end else begin
      r_cnt0 <= cnt_next(r_cnt0, w_inc[0], w_dec[0]);
      r_cnt1 <= cnt_next(r_cnt1, w_inc[1], w_dec[1]);
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_arid    <= {w_grant_idx, w_arid};
            r_araddr  <= w_araddr;
            r_arlen   <= w_arlen;
            r_arsize  <= w_arsize;
            r_arburst <= w_arburst;
            r_arvalid <= 1'b1;
            r_ptr     <= ~w_grant_idx;
            r_state   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (m_arready) begin
            r_arvalid <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign m_arid    = r_arid;
  assign m_araddr  = r_araddr;
  assign m_arlen   = r_arlen;
  assign m_arsize  = r_arsize;
  assign m_arburst = r_arburst;
  assign m_arvalid = r_arvalid;

`ifndef SYNTHESIS
  // An rlast with no burst in flight means the downstream and this block disagree.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(w_dec[0] && !w_inc[0] && r_cnt0 == 4'd0))
        else $error("axi_rd_arbiter: rlast for requester 0 with nothing outstanding");
      assert (!(w_dec[1] && !w_inc[1] && r_cnt1 == 4'd0))
        else $error("axi_rd_arbiter: rlast for requester 1 with nothing outstanding");
    end
  end
`endif

endmodule

// File: tb/tb_axi_rd_arbiter.sv
module tb_axi_rd_arbiter;
  localparam int IW = 7;
  localparam int AW = 64;
  localparam int DW = 512;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [2*IW-1:0] s_arid;
  logic [2*AW-1:0] s_araddr;
  logic [15:0]     s_arlen;
  logic [5:0]      s_arsize;
  logic [3:0]      s_arburst;
  logic [1:0]      s_arvalid;
  logic [1:0]      s_arready;
  logic [2*IW-1:0] s_rid;
  logic [2*DW-1:0] s_rdata;
  logic [3:0]      s_rresp;
  logic [1:0]      s_rlast;
  logic [1:0]      s_rvalid;
  logic [1:0]      s_rready;
  logic [IW:0]     m_arid;
  logic [AW-1:0]   m_araddr;
  logic [7:0]      m_arlen;
  logic [2:0]      m_arsize;
  logic [1:0]      m_arburst;
  logic            m_arvalid;
  logic            m_arready;
  logic [IW:0]     m_rid;
  logic [DW-1:0]   m_rdata;
  logic [1:0]      m_rresp;
  logic            m_rlast;
  logic            m_rvalid;
  logic            m_rready;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = '0; s_arburst = '0;
    s_arvalid = 2'b00; s_rready = 2'b00; m_arready = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic reset_dut;
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst_n = 1'b0;
    #3;
    nvec++; if (m_arvalid !== 1'b0) begin nerr++; $display("FAIL rst_arvalid got %b want 0", m_arvalid); end
    nvec++; if (m_arid !== 8'h00 || m_araddr !== 64'h0 || m_arlen !== 8'h00 || m_arsize !== 3'h0 || m_arburst !== 2'h0) begin
      nerr++; $display("FAIL rst_payload got id=%h addr=%h len=%h want all 0", m_arid, m_araddr, m_arlen); end
    nvec++; if (s_arready !== 2'b00 || s_rvalid !== 2'b00 || m_rready !== 1'b0) begin
      nerr++; $display("FAIL rst_handshakes got arready=%b rvalid=%b rready=%b want 0", s_arready, s_rvalid, m_rready); end
    nvec++; if (dut.r_cnt0 !== 4'd0 || dut.r_cnt1 !== 4'd0) begin
      nerr++; $display("FAIL rst_counters got %0d/%0d want 0/0", dut.r_cnt0, dut.r_cnt1); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      nvec++; if (m_arvalid !== 1'b0) begin nerr++; $display("FAIL idle_arvalid cycle %0d got %b want 0", c, m_arvalid); end
    end
  endtask

  task automatic test_single;
    int pulses;
    reset_dut();
    m_arready = 1'b1;
    s_arid[IW-1:0] = 7'h05; s_araddr[AW-1:0] = 64'h1000; s_arlen[7:0] = 8'd3;
    s_arsize[2:0] = 3'd6; s_arburst[1:0] = 2'b01; s_arvalid = 2'b01;
    #1;
    nvec++; if (s_arready !== 2'b01) begin nerr++; $display("FAIL single_arready got %b want 01", s_arready); end
    tick();
    s_arvalid = 2'b00;
    nvec++; if (m_arvalid !== 1'b1 || m_arid !== 8'h05 || m_araddr !== 64'h1000 || m_arlen !== 8'd3 || m_arsize !== 3'd6 || m_arburst !== 2'b01) begin
      nerr++; $display("FAIL single_ar got v=%b id=%h addr=%h len=%0d want 1/05/1000/3", m_arvalid, m_arid, m_araddr, m_arlen); end
    tick();
    nvec++; if (m_arvalid !== 1'b0 || dut.r_cnt0 !== 4'd1) begin
      nerr++; $display("FAIL single_issued got v=%b cnt0=%0d want 0/1", m_arvalid, dut.r_cnt0); end
    pulses = 0;
    s_rready = 2'b01;
    for (int b = 0; b < 4; b++) begin
      m_rvalid = 1'b1; m_rid = 8'h05; m_rlast = (b == 3); m_rresp = 2'b00; m_rdata = DW'(b + 100);
      #1;
      if (s_rvalid === 2'b01) pulses++;
      nvec++; if (s_rid[IW-1:0] !== 7'h05 || m_rready !== 1'b1 || s_rdata[2*DW-1:DW] !== DW'(b + 100)) begin
        nerr++; $display("FAIL single_beat%0d got rid=%h rready=%b want 05/1", b, s_rid[IW-1:0], m_rready); end
      tick();
    end
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    nvec++; if (pulses !== 4) begin nerr++; $display("FAIL single_pulses got %0d want 4", pulses); end
    nvec++; if (dut.r_cnt0 !== 4'd0) begin nerr++; $display("FAIL single_cnt0 got %0d want 0", dut.r_cnt0); end
  endtask

  task automatic test_fairness;
    logic       g;
    logic [7:0] exp_id;
    reset_dut();
    m_arready = 1'b1;
    s_arid = {7'h05, 7'h11};
    s_arvalid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      g = k[0];
      exp_id = g ? 8'h85 : 8'h11;
      #1;
      nvec++; if (s_arready !== (g ? 2'b10 : 2'b01)) begin nerr++; $display("FAIL fair_grant%0d got %b want %b", k, s_arready, g ? 2'b10 : 2'b01); end
      tick();
      nvec++; if (m_arvalid !== 1'b1 || m_arid !== exp_id) begin nerr++; $display("FAIL fair_arid%0d got %h want %h", k, m_arid, exp_id); end
      tick();
    end
    s_arvalid = 2'b00;
  endtask

  task automatic test_backpressure;
    reset_dut();
    m_arready = 1'b0;
    s_arid = {7'h22, 7'h33};
    s_araddr = {64'hB000, 64'hA000};
    s_arlen = {8'd7, 8'd1};
    s_arvalid = 2'b11;
    #1;
    nvec++; if (s_arready !== 2'b01) begin nerr++; $display("FAIL bp_first_grant got %b want 01", s_arready); end
    tick();
    s_araddr[AW-1:0] = 64'hDEAD;
    for (int c = 0; c < 5; c++) begin
      #1;
      nvec++; if (m_arvalid !== 1'b1 || m_arid !== 8'h33 || m_araddr !== 64'hA000 || m_arlen !== 8'd1 || s_arready !== 2'b00) begin
        nerr++; $display("FAIL bp_hold%0d got v=%b id=%h addr=%h arready=%b want 1/33/a000/00", c, m_arvalid, m_arid, m_araddr, s_arready); end
      tick();
    end
    m_arready = 1'b1;
    tick();
    nvec++; if (m_arvalid !== 1'b0 || s_arready !== 2'b10) begin
      nerr++; $display("FAIL bp_release got v=%b arready=%b want 0/10", m_arvalid, s_arready); end
    s_arvalid = 2'b00;
  endtask

  task automatic test_outstanding_cap;
    reset_dut();
    m_arready = 1'b1;
    s_arid = {7'h05, 7'h01};
    s_arvalid = 2'b10;
    for (int k = 0; k < 4; k++) begin
      #1;
      nvec++; if (s_arready !== 2'b10) begin nerr++; $display("FAIL cap_burst%0d got %b want 10", k, s_arready); end
      tick(); tick();
    end
    #1;
    nvec++; if (s_arready !== 2'b00 || dut.r_cnt1 !== 4'd4) begin
      nerr++; $display("FAIL cap_stall got arready=%b cnt1=%0d want 00/4", s_arready, dut.r_cnt1); end
    s_arvalid = 2'b11;
    #1;
    nvec++; if (s_arready !== 2'b01) begin nerr++; $display("FAIL cap_other_grant got %b want 01", s_arready); end
    tick();
    nvec++; if (m_arid !== 8'h01) begin nerr++; $display("FAIL cap_other_arid got %h want 01", m_arid); end
    tick();
    s_arvalid = 2'b10;
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 8'h85; s_rready = 2'b10;
    #1;
    nvec++; if (s_rvalid !== 2'b10 || m_rready !== 1'b1 || s_arready !== 2'b00) begin
      nerr++; $display("FAIL cap_rlast got rvalid=%b rready=%b arready=%b want 10/1/00", s_rvalid, m_rready, s_arready); end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0;
    #1;
    nvec++; if (s_arready !== 2'b10) begin nerr++; $display("FAIL cap_unstall got %b want 10", s_arready); end
    s_arvalid = 2'b00;
  endtask

  task automatic test_simul_and_reset;
    reset_dut();
    m_arready = 1'b1;
    s_arid = {7'h44, 7'h0A};
    s_arvalid = 2'b01;
    tick(); tick();
    m_rvalid = 1'b1; m_rlast = 1'b1; m_rid = 8'h00; s_rready = 2'b01;
    #1;
    nvec++; if (s_arready !== 2'b01 || m_rready !== 1'b1 || dut.r_cnt0 !== 4'd1) begin
      nerr++; $display("FAIL simul_setup got arready=%b rready=%b cnt0=%0d want 01/1/1", s_arready, m_rready, dut.r_cnt0); end
    tick();
    m_rvalid = 1'b0; m_rlast = 1'b0; s_arvalid = 2'b00;
    nvec++; if (dut.r_cnt0 !== 4'd1) begin nerr++; $display("FAIL simul_cnt0 got %0d want 1", dut.r_cnt0); end
    tick();
    s_arvalid = 2'b10;
    tick();
    s_arvalid = 2'b00;
    m_arready = 1'b0;
    nvec++; if (m_arvalid !== 1'b1 || m_arid !== 8'hC4) begin
      nerr++; $display("FAIL midrst_pre got v=%b id=%h want 1/c4", m_arvalid, m_arid); end
    #2 rst_n = 1'b0;
    #1;
    nvec++; if (m_arvalid !== 1'b0 || m_arid !== 8'h00 || dut.r_cnt0 !== 4'd0 || dut.r_cnt1 !== 4'd0) begin
      nerr++; $display("FAIL midrst got v=%b id=%h cnt=%0d/%0d want 0/00/0/0", m_arvalid, m_arid, dut.r_cnt0, dut.r_cnt1); end
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_outstanding_cap();
    test_simul_and_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/axi_rd_arbiter.md
Name: axi_rd_arbiter

Overview:
- Two-requester AXI4 read arbiter that shares one read master port, e.g. the crossbar read slave port or the DDR port, between the hawk engine and the CPU path.
- Arbitrates AR requests round-robin and prefixes each ARID with the requester index. Routes R beats back by the ARID MSB.
- Limits in-flight read bursts per requester so that neither requester can monopolise the downstream issue slots.

Parameters:
- ID_WIDTH, 7: requester-side ARID/RID width.
- ADDR_WIDTH, 64: address width.
- DATA_WIDTH, 512: read data width.
- MAX_OUTSTANDING, 4: maximum in-flight bursts per requester, range 1..15.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_arid  in  2*ID_WIDTH  per-requester ARID; requester 0 in the low slice.
- s_araddr  in  2*ADDR_WIDTH  per-requester address.
- s_arlen  in  2*8  per-requester burst length.
- s_arsize  in  2*3  per-requester size.
- s_arburst  in  2*2  per-requester burst type.
- s_arvalid  in  2  request valid.
- s_arready  out  2  request accepted.
- s_rid  out  2*ID_WIDTH  returned ID, with the prefix bit stripped.
- s_rdata  out  2*DATA_WIDTH  read data, broadcast to both requesters.
- s_rresp  out  2*2  response, broadcast.
- s_rlast  out  2  last beat, broadcast.
- s_rvalid  out  2  beat valid, routed to one requester.
- s_rready  in  2  beat ready.
- m_arid  out  ID_WIDTH+1  {grant index, s_arid}.
- m_araddr  out  ADDR_WIDTH  address.
- m_arlen  out  8  burst length.
- m_arsize  out  3  size.
- m_arburst  out  2  burst type.
- m_arvalid  out  1  request valid.
- m_arready  in  1  downstream accepts.
- m_rid  in  ID_WIDTH+1  returned ID.
- m_rdata  in  DATA_WIDTH  read data.
- m_rresp  in  2  response.
- m_rlast  in  1  last beat.
- m_rvalid  in  1  beat valid.
- m_rready  out  1  beat ready.

Behaviour:
- Reset, asynchronous on rst_n low:
  - m_arvalid=0, all m_ar* payload registers 0, s_arready=0.
  - Round-robin pointer = requester 0 has priority.
  - Both outstanding counters = 0, FSM = IDLE.
  - Reset mid-burst abandons all tracking; downstream must be reset together with this block.
- Eligibility: requester i is eligible when s_arvalid[i]=1 and cnt[i] < MAX_OUTSTANDING.
- FSM IDLE:
  - If any requester is eligible, grant it: the pointer's requester if eligible, otherwise the other one.
  - Same cycle: assert s_arready[grant] (single-cycle pulse; the other requester's bit stays 0) and capture its payload into the m_ar* registers with m_arid={grant,s_arid[grant]}.
  - Next cycle: m_arvalid=1, FSM = ISSUE.
  - The pointer moves to the non-granted requester.
  - Latency from s_arvalid to m_arvalid is 1 cycle.
- FSM ISSUE:
  - Hold m_ar* stable until m_arready=1.
  - On handshake: m_arvalid=0, FSM = IDLE.
  - No new grant while in ISSUE, so the AR channel issues at most one request per two cycles.
- Counters:
  - cnt[grant] increments at s_ar handshake, i.e. at the grant.
  - cnt[j] decrements on m_rvalid & m_rready & m_rlast with m_rid[ID_WIDTH]=j.
  - If the increment and decrement for the same requester fall in the same cycle, the count is unchanged.
  - A counter at MAX_OUTSTANDING blocks that requester only; the other requester proceeds.
  - Counter width is 4 bits. Decrement at 0 is illegal: saturate at 0 and flag in simulation assertion.
- R routing, combinational and zero latency:
  - sel = m_rid[ID_WIDTH].
  - s_rvalid[sel]=m_rvalid; the other bit = 0.
  - m_rready = s_rready[sel].
  - s_rid = m_rid[ID_WIDTH-1:0] in both slices.
  - rdata, rresp and rlast are broadcast to both slices.
  - Beats for different requesters may interleave at burst boundaries; no reordering is performed.
- Simultaneous AR requests from both requesters with pointer=0: requester 0 wins, then requester 1 on the next IDLE cycle.

Test Plan:
- Reset then idle: check all outputs 0 with rst_n low; release reset with no stimulus → m_arvalid stays 0 for 10 cycles.
- Single request: requester 0 sends arid=7'h05, addr=0x1000, len=3, m_arready=1 → m_arid=8'h05 one cycle later. Return 4 beats with rid=8'h05 → s_rvalid[0] pulses 4 times, s_rid=7'h05, cnt0 ends at 0.
- Fairness: both requesters hold arvalid continuously, m_arready=1, R returned promptly → grant order 0,1,0,1; each m_arid has the correct prefix (requester 1 arid=7'h05 → 8'h85).
- Backpressure: m_arready=0 for 5 cycles → m_ar* payload stable, s_arready both 0 until the handshake completes.
- Outstanding cap: requester 1 issues 4 bursts with no R returned → 5th request stalls (s_arready[1]=0) while requester 0 is still granted. One rlast for requester 1 → stall released the next cycle.
- Simultaneous increment/decrement and reset mid-traffic: requester 0 is granted in the same cycle as an rlast for requester 0 → cnt0 unchanged. Assert rst_n low mid-burst → m_arvalid=0 immediately, counters 0.
